// File: rtl/traffic_mode_select_if.sv
// rtl/traffic_mode_select_if.sv - detector/sequencer side-band bundle for traffic_mode_select
// Ports:
//   car_raw     - raw vehicle detector level (asynchronous, may bounce)
//   cycle_start - one-clock pulse at the start of each red phase
//   mode        - 0 = heavy (long tics), 1 = light (short tics)
//   mode_change - one-clock pulse after mode takes a new value
//   car_count   - vehicle count of the last completed window
interface traffic_mode_select_if;
    logic       car_raw;
    logic       cycle_start;
    logic       mode;
    logic       mode_change;
    logic [7:0] car_count;

    modport master (
        output car_raw,
        output cycle_start,
        input  mode,
        input  mode_change,
        input  car_count
    );

    modport slave (
        input  car_raw,
        input  cycle_start,
        output mode,
        output mode_change,
        output car_count
    );
endinterface

// File: rtl/traffic_mode_select.sv
// rtl/traffic_mode_select.sv - traffic density classifier choosing heavy/light sequencer mode
// Ports:
//   clock   - system clock, all state on posedge
//   reset_n - asynchronous active-low reset
//   bus     - traffic_mode_select_if.slave (car_raw, cycle_start in; mode, mode_change, car_count out)
module traffic_mode_select #(
    parameter int DEBOUNCE_TICS = 4,
    parameter int WINDOW_TICS   = 1000,
    parameter int HIGH_THRESH   = 20,
    parameter int LOW_THRESH    = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    traffic_mode_select_if.slave   bus
);
    localparam int DW = $clog2(DEBOUNCE_TICS + 1);
    localparam int WW = (WINDOW_TICS > 1) ? $clog2(WINDOW_TICS) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICS - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_TICS - 1);

    typedef enum logic [1:0] {
        HEAVY      = 2'd0,
        LIGHT      = 2'd1,
        PEND_LIGHT = 2'd2,
        PEND_HEAVY = 2'd3
    } state_t;

    logic          sync1, sync2;
    logic          car_stable;
    logic [DW-1:0] deb_cnt;
    logic [WW-1:0] win_cnt;
    logic [7:0]    acc;
    logic [7:0]    acc_next;
    logic [7:0]    count_q;
    logic          req_heavy, req_light;
    logic          differ, accept, car_event, win_end;
    state_t        state;
    logic          mode_q, mode_change_q;

    always_comb begin
        differ    = (sync2 != car_stable);
        accept    = differ && (deb_cnt == DEB_LAST);
        // A rising acceptance is the car event; it is counted on the same
        // edge that car_stable goes high.
        car_event = accept && sync2;
        win_end   = (win_cnt == WIN_LAST);
        acc_next  = (car_event && (acc != 8'hFF)) ? acc + 8'd1 : acc;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.car_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            car_stable <= 1'b0;
            deb_cnt    <= '0;
        end else if (!differ) begin
            deb_cnt    <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            car_stable <= sync2;
            deb_cnt    <= '0;
        end else begin
            deb_cnt    <= deb_cnt + DW'(1);
        end
    end

    // Requests are registered one-clock pulses, so a window end that
    // coincides with cycle_start is seen by the FSM only on the next clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt   <= '0;
            acc       <= '0;
            count_q   <= '0;
            req_heavy <= 1'b0;
            req_light <= 1'b0;
        end else begin
            req_heavy <= 1'b0;
            req_light <= 1'b0;
            if (win_end) begin
                win_cnt   <= '0;
                acc       <= '0;
                count_q   <= acc_next;
                req_heavy <= (int'(acc_next) >= HIGH_THRESH);
                req_light <= (int'(acc_next) <= LOW_THRESH);
            end else begin
                win_cnt   <= win_cnt + WW'(1);
                acc       <= acc_next;
            end
        end
    end

    // Pending states keep the old mode until the sequencer starts a new red
    // phase; a contrary request while pending cancels without touching mode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= HEAVY;
            mode_q        <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            mode_change_q <= 1'b0;
            case (state)
                HEAVY: begin
                    if (req_light) state <= PEND_LIGHT;
                end
                LIGHT: begin
                    if (req_heavy) state <= PEND_HEAVY;
                end
                PEND_LIGHT: begin
                    if (req_heavy) begin
                        state <= HEAVY;
                    end else if (bus.cycle_start) begin
                        state         <= LIGHT;
                        mode_q        <= 1'b1;
                        mode_change_q <= 1'b1;
                    end
                end
                PEND_HEAVY: begin
                    if (req_light) begin
                        state <= LIGHT;
                    end else if (bus.cycle_start) begin
                        state         <= HEAVY;
                        mode_q        <= 1'b0;
                        mode_change_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= HEAVY;
                    mode_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mode        = mode_q;
    assign bus.mode_change = mode_change_q;
    assign bus.car_count   = count_q;
endmodule

// File: tb/tb_traffic_mode_select.sv
// tb/tb_traffic_mode_select.sv - randomized and directed bench for traffic_mode_select
module tb_traffic_mode_select;
    localparam int DEB = 4;
    localparam int W   = 100;
    localparam int H   = 5;
    localparam int L   = 2;
    localparam int WS  = 4000;

    logic clock;
    logic reset_n;
    logic sat_rst_n;

    traffic_mode_select_if dut_if ();
    traffic_mode_select_if sat_if ();

    traffic_mode_select #(
        .DEBOUNCE_TICS(DEB), .WINDOW_TICS(W), .HIGH_THRESH(H), .LOW_THRESH(L)
    ) u_dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (dut_if)
    );

    traffic_mode_select #(
        .DEBOUNCE_TICS(DEB), .WINDOW_TICS(WS), .HIGH_THRESH(H), .LOW_THRESH(L)
    ) u_sat (
        .clock  (clock),
        .reset_n(sat_rst_n),
        .bus    (sat_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit sat_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the settled mode and the mode the traffic
    // currently asks for; a pending change is simply want != mode.
    logic m_s1, m_s2, m_stable, m_mode, m_want, m_mc;
    int   m_run, m_wcnt, m_acc, m_count, m_req, m_ev, m_tot;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_run = 0;
            m_wcnt = 0; m_acc = 0; m_count = 0; m_req = -1;
            m_mode = 0; m_want = 0; m_mc = 0;
        end else begin
            m_ev = 0;
            if (m_s2 != m_stable) begin
                m_run++;
                if (m_run == DEB) begin
                    m_stable = m_s2;
                    m_run = 0;
                    m_ev = m_s2 ? 1 : 0;
                end
            end else begin
                m_run = 0;
            end
            m_mc = 0;
            if (m_req >= 0 && m_req != int'(m_want)) begin
                m_want = m_req[0];
            end else if (dut_if.cycle_start && m_want != m_mode) begin
                m_mode = m_want;
                m_mc = 1;
            end
            m_tot = (m_acc + m_ev > 255) ? 255 : m_acc + m_ev;
            if (m_wcnt == W - 1) begin
                m_count = m_tot;
                m_acc = 0;
                m_req = (m_tot >= H) ? 0 : (m_tot <= L) ? 1 : -1;
                m_wcnt = 0;
            end else begin
                m_acc = m_tot;
                m_req = -1;
                m_wcnt++;
            end
            m_s2 = m_s1;
            m_s1 = dut_if.car_raw;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("mode", dut_if.mode, m_mode);
            check("mode_change", dut_if.mode_change, m_mc);
            check("car_count", dut_if.car_count, m_count);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cars(input int n);
        repeat (n) begin
            dut_if.car_raw = 1'b1; tick(6);
            dut_if.car_raw = 1'b0; tick(6);
        end
    endtask

    task automatic wait_win_start;
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (m_wcnt != 0 && k < 300);
    endtask

    task automatic pulse_cs;
        dut_if.cycle_start = 1'b1;
        tick(1);
        dut_if.cycle_start = 1'b0;
    endtask

    // Saturation: 300 clean cars in one long window must read back as 255.
    initial begin
        sat_rst_n = 1'b0;
        sat_if.car_raw = 1'b0;
        sat_if.cycle_start = 1'b0;
        tick(3);
        sat_rst_n = 1'b1;
        repeat (300) begin
            sat_if.car_raw = 1'b1; tick(6);
            sat_if.car_raw = 1'b0; tick(6);
        end
        tick(399);
        check("sat_before_end", sat_if.car_count, 0);
        tick(1);
        check("sat_count", sat_if.car_count, 255);
        sat_done = 1'b1;
    end

    initial begin
        int hold;
        reset_n = 1'b0;
        dut_if.car_raw = 1'b0;
        dut_if.cycle_start = 1'b0;
        tick(3);
        chk_en = 1'b1;
        check("rst_mode", dut_if.mode, 0);
        check("rst_mode_change", dut_if.mode_change, 0);
        check("rst_car_count", dut_if.car_count, 0);
        reset_n = 1'b1;

        // Bounce: 3-clock highs never survive debounce.
        repeat (15) begin
            dut_if.car_raw = 1'b1; tick(3);
            dut_if.car_raw = 1'b0; tick(3);
        end
        wait_win_start();
        check("bounce_count", dut_if.car_count, 0);

        // Light traffic: one car, change waits for cycle_start.
        cars(1);
        wait_win_start();
        check("light_count", dut_if.car_count, 1);
        tick(9);
        check("light_mode_pend", dut_if.mode, 0);
        pulse_cs();
        check("light_mode", dut_if.mode, 1);
        check("light_mc", dut_if.mode_change, 1);
        tick(1);
        check("light_mc_end", dut_if.mode_change, 0);

        // Hysteresis: 3 cars is between thresholds, 5 cars is heavy.
        cars(3);
        wait_win_start();
        check("hyst_count3", dut_if.car_count, 3);
        tick(5);
        pulse_cs();
        check("hyst_mode_hold", dut_if.mode, 1);
        check("hyst_mc_none", dut_if.mode_change, 0);
        cars(5);
        wait_win_start();
        check("hyst_count5", dut_if.car_count, 5);
        tick(5);
        check("hyst_mode_pend", dut_if.mode, 1);
        pulse_cs();
        check("hyst_mode_heavy", dut_if.mode, 0);
        check("hyst_mc", dut_if.mode_change, 1);

        // Cancel: light request withdrawn by a heavy window before cycle_start.
        cars(1);
        wait_win_start();
        check("cancel_count1", dut_if.car_count, 1);
        cars(6);
        wait_win_start();
        check("cancel_count6", dut_if.car_count, 6);
        tick(3);
        pulse_cs();
        check("cancel_mode", dut_if.mode, 0);
        check("cancel_mc", dut_if.mode_change, 0);

        // Coincidence: cycle_start on the window-end clock of a light window.
        begin
            int k;
            k = 0;
            while (m_wcnt != W - 1 && k < 300) begin
                tick(1);
                k++;
            end
        end
        pulse_cs();
        check("coin_count", dut_if.car_count, 0);
        check("coin_mode", dut_if.mode, 0);
        check("coin_mc", dut_if.mode_change, 0);
        tick(3);
        check("coin_mode_pend", dut_if.mode, 0);
        pulse_cs();
        check("coin_mode_next", dut_if.mode, 1);
        check("coin_mc_next", dut_if.mode_change, 1);

        // Reset in PEND_HEAVY with four cars accumulated.
        cars(5);
        wait_win_start();
        check("rst_pre_count", dut_if.car_count, 5);
        cars(4);
        tick(2);
        check("rst_pre_mode", dut_if.mode, 1);
        #3 reset_n = 1'b0;
        #1;
        check("rst_async_mode", dut_if.mode, 0);
        check("rst_async_count", dut_if.car_count, 0);
        check("rst_async_mc", dut_if.mode_change, 0);
        tick(2);
        reset_n = 1'b1;
        cars(2);
        wait_win_start();
        check("rst_post_count", dut_if.car_count, 2);
        check("rst_post_mode", dut_if.mode, 0);

        // Randomized traffic, sequencer pulses and occasional resets.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                dut_if.car_raw = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            dut_if.cycle_start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                #2 reset_n = 1'b0;
                tick(2);
                reset_n = 1'b1;
            end
            tick(1);
        end
        dut_if.cycle_start = 1'b0;

        for (int i = 0; i < 10000 && !sat_done; i++) tick(1);
        check("sat_finished", sat_done, 1);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_mode_select.md
TRAFFIC_MODE_SELECT -- requirements
Module: traffic_mode_select

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICS, default 4: consecutive clocks a new detector level must hold before acceptance.
REQ-002 SHALL have parameter WINDOW_TICS, default 1000: length in clocks of one vehicle-counting window.
REQ-003 SHALL have parameter HIGH_THRESH, default 20: window count at or above which traffic is heavy.
REQ-004 SHALL have parameter LOW_THRESH, default 8: window count at or below which traffic is light; LOW_THRESH < HIGH_THRESH.
REQ-005 SHALL have port clock, input, 1: single system clock; all state updates on posedge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port car_raw, input, 1: vehicle detector level, asynchronous to clock, may bounce.
REQ-008 SHALL have port cycle_start, input, 1: one-clock pulse from the light sequencer at the start of each red phase.
REQ-009 SHALL have port mode, output, 1: 0 = heavy (long red/green tics), 1 = light (short tics); drives the sequencer's mode input.
REQ-010 SHALL have port mode_change, output, 1: one-clock pulse in the cycle mode takes a new value.
REQ-011 SHALL have port car_count, output, 8: vehicle count of the last completed window.

Function
REQ-012 SHALL pass car_raw through a 2-flop synchronizer before any other use.
REQ-013 SHALL update debounced level car_stable only after the synchronized input differs from car_stable for DEBOUNCE_TICS consecutive clocks; any agreeing clock clears the debounce counter.
REQ-014 SHALL generate one internal car event per 0->1 transition of car_stable; 1->0 transitions generate none.
REQ-015 SHALL run a window counter 0..WINDOW_TICS-1, wrapping to 0; the clock with value WINDOW_TICS-1 is window end.
REQ-016 SHALL accumulate car events in an 8-bit counter saturating at 255 (no wrap).
REQ-017 At window end, SHALL load car_count with the accumulated value (including an event in that same clock) and clear the accumulator to 0.
REQ-018 At window end, SHALL classify: count >= HIGH_THRESH -> request heavy; count <= LOW_THRESH -> request light; otherwise no request (hysteresis).
REQ-019 SHALL implement mode FSM states HEAVY (mode 0), LIGHT (mode 1), PEND_LIGHT (mode 0), PEND_HEAVY (mode 1).
REQ-020 Transitions: HEAVY + light request -> PEND_LIGHT; LIGHT + heavy request -> PEND_HEAVY; PEND_LIGHT + heavy request -> HEAVY; PEND_HEAVY + light request -> LIGHT; all others hold until cycle_start.
REQ-021 On cycle_start: PEND_LIGHT -> LIGHT, PEND_HEAVY -> HEAVY; in HEAVY/LIGHT cycle_start has no effect.
REQ-022 mode SHALL be registered and change only on the clock edge on which cycle_start is sampled high in a PEND state, i.e. never mid-phase.
REQ-023 mode_change SHALL be high for exactly the one clock following that edge, and only when mode changed value.
REQ-024 If window end and cycle_start coincide, SHALL apply cycle_start to the pre-update state; the new request takes effect from the next clock and waits for the next cycle_start.
REQ-025 A request matching current mode SHALL cause no state change and no mode_change.

Reset
REQ-026 While reset_n low SHALL force: state HEAVY, mode 0, mode_change 0, car_count 0, accumulator 0, window counter 0, debounce counter 0, car_stable 0, synchronizer flops 0.
REQ-027 Reset assertion mid-window or in a PEND state SHALL discard the window and pending request; counting restarts from 0 on the first clock after release.

Verification (DEBOUNCE_TICS=4, WINDOW_TICS=100, HIGH_THRESH=5, LOW_THRESH=2)
REQ-028 Bounce: car_raw high for 3 clocks then low, repeated -> no car event, car_count 0 at window end.
REQ-029 Light traffic: 1 clean car in window, cycle_start 10 clocks after window end -> car_count 1, state PEND_LIGHT, mode 0 until cycle_start, then mode 1 with mode_change pulse of 1 clock.
REQ-030 Hysteresis: from LIGHT, window with 3 cars -> no request, mode stays 1, no mode_change; next window with 5 cars -> PEND_HEAVY, mode 0 at next cycle_start.
REQ-031 Cancel: PEND_LIGHT, next window 6 cars before any cycle_start -> back to HEAVY, mode never leaves 0, no mode_change.
REQ-032 Saturation/coincidence: 300 car events in one window -> car_count 255; window end coinciding with cycle_start and light request -> mode unchanged that cycle, changes on the following cycle_start.
REQ-033 Reset: assert reset_n low in PEND_HEAVY with accumulator 4 -> mode 0, car_count 0 immediately (asynchronous); after release first window counts from 0.
